// File: rtl/route_compute_vc.sv
// Per-VC registered route computation (XY/YX dimension order) with packet counter and error pulse.
// Optional macro ROUTE_RANGE_CHECK_EN: out-of-mesh destinations are sunk locally and flagged.
module route_compute_vc #(
  parameter int X_CURRENT  = 3,
  parameter int Y_CURRENT  = 3,
  parameter int X_ADDR_W   = 5,
  parameter int Y_ADDR_W   = 5,
  parameter int NUM_VC     = 2,
  parameter int ROUTE_MODE = 0,
  parameter int MESH_X     = 8,
  parameter int MESH_Y     = 8,
  parameter int CNT_W      = 16,
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flit_valid_i,
  input  logic                  flit_head_i,
  input  logic [VC_W-1:0]       flit_vc_i,
  input  logic [X_ADDR_W-1:0]   x_dest_i,
  input  logic [Y_ADDR_W-1:0]   y_dest_i,
  input  logic [NUM_VC-1:0]     route_release_i,
  output logic [NUM_VC-1:0]     route_valid_o,
  output logic [NUM_VC*3-1:0]   route_port_o,
  output logic                  proto_err_o,
  output logic [CNT_W-1:0]      pkt_cnt_o
);

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_SOUTH = 3'd2;
  localparam logic [2:0] P_WEST  = 3'd3;
  localparam logic [2:0] P_EAST  = 3'd4;

  localparam logic [31:0] XC = 32'(X_CURRENT);
  localparam logic [31:0] YC = 32'(Y_CURRENT);

  typedef enum logic {IDLE, ROUTED} state_t;

  state_t                state_q [NUM_VC];
  state_t                state_d [NUM_VC];
  logic [NUM_VC*3-1:0]   port_q, port_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [31:0]           x_ext, y_ext;
  logic                  range_raw, range_bad;
  logic                  vc_ok, head_ok, load;
  logic [NUM_VC-1:0]     hit;
  logic [2:0]            x_port, y_port, port_calc;

  assign x_ext     = 32'(x_dest_i);
  assign y_ext     = 32'(y_dest_i);
  assign range_raw = (x_ext >= 32'(MESH_X)) || (y_ext >= 32'(MESH_Y));
`ifdef ROUTE_RANGE_CHECK_EN
  assign range_bad = range_raw;
`else
  // Range check disabled: the mesh-size comparison is computed but never takes effect.
  assign range_bad = 1'b0 & range_raw;
`endif

  assign vc_ok   = (32'(flit_vc_i) < NUM_VC);
  assign head_ok = flit_valid_i & flit_head_i & vc_ok;

  always_comb begin
    x_port    = (x_ext > XC) ? P_EAST  : P_WEST;
    y_port    = (y_ext > YC) ? P_SOUTH : P_NORTH;
    port_calc = P_LOCAL;
    if (ROUTE_MODE == 0) begin
      if (x_ext != XC)      port_calc = x_port;
      else if (y_ext != YC) port_calc = y_port;
    end else begin
      if (y_ext != YC)      port_calc = y_port;
      else if (x_ext != XC) port_calc = x_port;
    end
    if (range_bad) port_calc = P_LOCAL;
  end

  always_comb begin
    hit = '0;
    for (int v = 0; v < NUM_VC; v++) hit[v] = head_ok & (32'(flit_vc_i) == v);
  end

  // A release and a head on the same VC in one cycle is a release followed by a reload.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    err_d   = flit_valid_i & ~vc_ok;
    load    = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      case (state_q[v])
        IDLE: begin
          if (hit[v]) begin
            state_d[v]        = ROUTED;
            port_d[3*v +: 3]  = port_calc;
            load              = 1'b1;
          end
        end
        ROUTED: begin
          if (route_release_i[v]) begin
            if (hit[v]) begin
              port_d[3*v +: 3] = port_calc;
              load             = 1'b1;
            end else begin
              state_d[v] = IDLE;
            end
          end else if (hit[v]) begin
            err_d = 1'b1;
          end
        end
        default: state_d[v] = IDLE;
      endcase
    end
    if (load && range_bad) err_d = 1'b1;
    cnt_d = load ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= IDLE;
      port_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= state_d[v];
      port_q <= port_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    route_valid_o = '0;
    for (int v = 0; v < NUM_VC; v++) route_valid_o[v] = (state_q[v] == ROUTED);
  end

  assign route_port_o = port_q;
  assign proto_err_o  = err_q;
  assign pkt_cnt_o    = cnt_q;

endmodule

// File: doc/route_compute_vc.md
Name: route_compute_vc

Overview:
- Registered, per-virtual-channel route computation unit for the mesh router input port.
- On each accepted head flit it computes the output port for the packet's destination, using XY or YX dimension-order routing, and latches it in that VC's route register.
- The route is held until the switch allocator releases it after the tail flit departs.
- Successor to the combinational route_Computation: adds VCs, selectable routing mode, a packet counter and a protocol-error flag.

Parameters:
- X_CURRENT, 3, X coordinate of this router
- Y_CURRENT, 3, Y coordinate of this router
- X_ADDR_W, 5, width of X destination field
- Y_ADDR_W, 5, width of Y destination field
- NUM_VC, 2, number of virtual channels (>=1); VC_W = max(1, $clog2(NUM_VC))
- ROUTE_MODE, 0, 0 = XY (X resolved first), 1 = YX (Y resolved first)
- MESH_X, 8, mesh columns (used only by optional feature)
- MESH_Y, 8, mesh rows (used only by optional feature)
- CNT_W, 16, packet counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flit_valid_i  in  1  flit present this cycle
- flit_head_i  in  1  flit is a head flit
- flit_vc_i  in  VC_W  VC of the flit
- x_dest_i  in  X_ADDR_W  destination X (meaningful with head only)
- y_dest_i  in  Y_ADDR_W  destination Y (meaningful with head only)
- route_release_i  in  NUM_VC  per-VC release pulse from the switch allocator
- route_valid_o  out  NUM_VC  per-VC route register valid
- route_port_o  out  NUM_VC*3  per-VC port; VC v occupies bits [3v+2:3v]
- proto_err_o  out  1  one-cycle pulse on a protocol violation
- pkt_cnt_o  out  CNT_W  count of routes loaded

Behaviour:
- Port encoding (3 bits): LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4. Values 5-7 are never driven.
- Directions:
  - x_dest > X_CURRENT -> EAST; x_dest < X_CURRENT -> WEST.
  - y_dest > Y_CURRENT -> SOUTH; y_dest < Y_CURRENT -> NORTH.
  - Comparisons are unsigned, zero-extended to the larger width.
- XY mode: if x differs, route in X; else if y differs, route in Y; else LOCAL.
- YX mode: if y differs, route in Y; else if x differs, route in X; else LOCAL.
- Per-VC state machine, states IDLE and ROUTED:
  - IDLE -> ROUTED: flit_valid_i & flit_head_i & flit_vc_i==v. The computed port is registered; route_valid_o[v]=1 and route_port_o[v] are valid on the next edge (latency 1 cycle).
  - ROUTED -> IDLE: route_release_i[v]=1 at the edge. route_valid_o[v]=0 next cycle; route_port_o[v] keeps its last value.
  - ROUTED with head on v and no release: head ignored, route unchanged, proto_err_o=1 for one cycle.
  - ROUTED with head on v and release[v] in the same cycle: release then reload. State stays ROUTED with the new port, no error, pkt_cnt increments.
  - Release on an IDLE VC: no effect, no error.
- Non-head flits never change state.
- flit_vc_i >= NUM_VC: flit ignored, proto_err_o pulses.
- pkt_cnt_o increments by 1 on each route load and wraps from all-ones to 0.
- Reset values: route_valid_o=0, route_port_o=0 (LOCAL) for all VCs, proto_err_o=0, pkt_cnt_o=0, all VCs IDLE.
- Reset asserted mid-packet clears state immediately, regardless of clock.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: ROUTE_RANGE_CHECK_EN.
- When defined: a head with x_dest >= MESH_X or y_dest >= MESH_Y is treated as a violation.
  - The route is still loaded, with port LOCAL, so the packet is sunk locally.
  - proto_err_o pulses.
  - pkt_cnt_o increments.
- When undefined: no range check. The port is computed purely from the comparisons and MESH_X/MESH_Y are unused.

Test Plan:
- XY mode, default params, VC0 head with dest (5,5) -> next cycle route_valid_o[0]=1, port=EAST; dest (3,1) on VC1 -> port=NORTH; dest (3,3) -> LOCAL.
- ROUTE_MODE=1, head dest (5,1) -> port=NORTH (XY would give EAST); dest (1,3) -> WEST.
- VC0 ROUTED, second head on VC0 without release -> proto_err_o=1 for one cycle, port unchanged, pkt_cnt_o unchanged; repeat with route_release_i[0]=1 in the same cycle -> new port loaded, no error, pkt_cnt_o +1.
- Heads on VC0 then VC1, release VC0 only -> route_valid_o=2'b10, VC1 port intact; release on an IDLE VC -> no change, no error.
- CNT_W=4, 16 head/release pairs -> pkt_cnt_o wraps 15->0; assert rst mid-packet (asynchronously, between edges) -> all outputs zero immediately.
- ROUTE_RANGE_CHECK_EN defined, MESH_X=8, head dest (9,2) -> port=LOCAL, proto_err_o pulse; undefined -> port=EAST, no error.
